code25_scan_display: RTL and testbench

Time-multiplexed, N-digit 7-segment driver for 2-of-5 coded digits. Latches a bank of 5-bit codes, validates each one, and decodes valid codes to segments. Invalid codes (popcount ≠ 2) show a flagged "E". Scans one digit at a time through a one-hot digit enable and sits between the 2-of-5 code sources and the board's common-cathode display bank.

---
 rtl/code25_scan_display.sv | 111 +++++++++++
 tb/tb_code25_scan_display.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/code25_scan_display.sv
// code25_scan_display: time-multiplexed 7-segment driver for a bank of 2-of-5 coded digits
// Optional feature macro: CODE25_BLINK_EN (blinks error digits; absent = steady "E")
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   code_in          DIGITS x 5-bit codes, digit k at [5k+4:5k], weights 7,4,2,1,0
//   load             capture code_in into the bank
//   blank            force seg/dp/digit_en dark, scanning continues
//   seg, dp          segments {G,F,E,D,C,B,A} and decimal point (error marker)
//   digit_en         one-hot common enable
//   err_flags        per-digit invalid-code flags
//   err_any          OR of err_flags
module code25_scan_display #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5*DIGITS-1:0]   code_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic [DIGITS-1:0]     err_flags,
  output logic                  err_any
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DIGITS-1:0][4:0] bank;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   last, dark, dp_nx;
  logic [7:0]             dec;
  logic [6:0]             seg_nx;
  logic [DIGITS-1:0]      err_nx, en_nx;

  // {dp, seg}; anything that is not exactly two-hot falls to the flagged "E"
  function automatic logic [7:0] decode(input logic [4:0] c);
    case (c)
      5'b11000: return 8'h3F;
      5'b00011: return 8'h06;
      5'b00101: return 8'h5B;
      5'b00110: return 8'h4F;
      5'b01001: return 8'h66;
      5'b01010: return 8'h6D;
      5'b01100: return 8'h7D;
      5'b10001: return 8'h07;
      5'b10010: return 8'h7F;
      5'b10100: return 8'h6F;
      default:  return 8'hF9;
    endcase
  endfunction

  assign last    = cnt == CNT_LAST;
  assign err_any = |err_flags;

  always_comb begin
    err_nx = '0;
    dec    = decode(bank[idx]);
    for (int k = 0; k < DIGITS; k++) err_nx[k] = $countones(bank[k]) != 2;
    // last prescaler cycle of each slot is a dark guard cycle against ghosting
    en_nx  = (blank || last) ? '0 : DIGITS'(1) << idx;
    {dp_nx, seg_nx} = (blank || last || dark) ? 8'd0 : dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank      <= {DIGITS{5'b11000}};
      cnt       <= '0;
      idx       <= '0;
      seg       <= '0;
      dp        <= 1'b0;
      digit_en  <= '0;
      err_flags <= '0;
    end else begin
      if (load) bank <= code_in;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      seg       <= seg_nx;
      dp        <= dp_nx;
      digit_en  <= en_nx;
      err_flags <= err_nx;
    end
  end

`ifdef CODE25_BLINK_EN
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);
  logic          phase;
  logic [FW-1:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b1;
    end else if (last && idx == IDX_LAST) begin
      fcnt <= (fcnt == FRM_LAST) ? '0 : fcnt + 1'b1;
      if (fcnt == FRM_LAST) phase <= ~phase;
    end
  end

  // error digits go dark in phase 0 while their enable stays asserted
  assign dark = dec[7] & ~phase;
`else
  assign dark = 1'b0;
`endif
endmodule

// File: tb/tb_code25_scan_display.sv
// tb_code25_scan_display: randomized scoreboard bench for code25_scan_display
module tb_code25_scan_display;
  localparam int D = 4, SD = 4, BD = 2;

  logic           clk = 0, rst_n = 0, load = 0, blank = 0;
  logic [5*D-1:0] code_in = '0;
  logic [6:0]     seg;
  logic           dp, err_any;
  logic [D-1:0]   digit_en, err_flags;
  int             checks = 0, passed = 0;

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [D-1:0] en;
    logic [D-1:0] ef;
    logic         ea;
  } exp_t;

  exp_t       q[$];
  logic [4:0] mb[D];
  int         k;
  logic [6:0] tbl[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [4:0] vcode[10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                            5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

  code25_scan_display #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .load(load), .blank(blank),
    .seg(seg), .dp(dp), .digit_en(digit_en), .err_flags(err_flags), .err_any(err_any)
  );

  always #5 clk = ~clk;

  function automatic int digit_val(input logic [4:0] c);
    int v;
    v = 7 * c[4] + 4 * c[3] + 2 * c[2] + c[1];
    return v == 11 ? 0 : v;
  endfunction

  // reference: scan position derived from the cycle count since reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      k = 0;
      for (int d = 0; d < D; d++) mb[d] = 5'b11000;
    end else begin
      exp_t e;
      int cnt, idx;
      logic ph;
      logic [4:0] c;
      cnt = k % SD;
      idx = (k / SD) % D;
`ifdef CODE25_BLINK_EN
      ph = ((k / (SD * D) / BD) % 2) == 0;
`else
      ph = 1'b1;
`endif
      c = mb[idx];
      e = '0;
      for (int d = 0; d < D; d++) e.ef[d] = $countones(mb[d]) != 2;
      e.ea = |e.ef;
      if (!blank && cnt != SD - 1) begin
        e.en = D'(1) << idx;
        if ($countones(c) == 2) e.seg = tbl[digit_val(c)];
        else if (ph) begin
          e.seg = 7'h79;
          e.dp  = 1'b1;
        end
      end
      q.push_back(e);
      if (load) for (int d = 0; d < D; d++) mb[d] = code_in[5*d +: 5];
      k++;
    end
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {seg, dp, digit_en, err_flags, err_any};
      checks++;
      if (a == e) passed++;
      else $display("FAIL scan t=%0t got seg=%b dp=%b en=%b ef=%b ea=%b want seg=%b dp=%b en=%b ef=%b ea=%b",
                    $time, a.seg, a.dp, a.en, a.ef, a.ea, e.seg, e.dp, e.en, e.ef, e.ea);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act == want) passed++;
    else $display("FAIL %s got %h want %h", name, act, want);
  endtask

  task automatic do_load(input logic [5*D-1:0] c);
    @(negedge clk);
    code_in = c;
    load = 1;
    @(negedge clk);
    load = 0;
  endtask

  initial begin
    logic [5*D-1:0] c;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({seg, dp, digit_en, err_flags, err_any}), 0);
    rst_n = 1;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < D; d++) c[5*d +: 5] = vcode[(i + d) % 10];
      do_load(c);
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    do_load({5'b11111, 5'b01010, 5'b11100, 5'b00000});
    @(negedge clk);
    chk("err_flags_1011", 32'(err_flags), 32'b1011);
    chk("err_any_set", 32'(err_any), 1);
    repeat (130) @(negedge clk);
    repeat (5) @(negedge clk);
    blank = 1;
    repeat (10) @(negedge clk);
    blank = 0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      load  = ($urandom % 8) == 0;
      blank = ($urandom % 16) == 0;
      for (int d = 0; d < D; d++)
        c[5*d +: 5] = ($urandom % 2) ? vcode[$urandom_range(0, 9)] : 5'($urandom);
      code_in = c;
    end
    load = 0;
    blank = 0;
    do_load({D{5'b11111}});
    repeat (6) @(negedge clk);
    #1 rst_n = 0;
    #1 chk("rst_async", 32'({seg, dp, digit_en, err_flags, err_any}), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_en", 32'(digit_en), 32'b0001);
    chk("post_rst_seg", 32'(seg), 32'h3F);
    repeat (40) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
